// File: rtl/uriscv_muldiv_arb.sv
// rtl/uriscv_muldiv_arb.sv - two-port round-robin arbiter/sequencer for the shared M-extension unit
// One op in flight at a time; a watchdog turns a missing completion into an error response.
module uriscv_muldiv_arb #(
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_ra_i,
    input  logic [31:0] req0_rb_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_ra_i,
    input  logic [31:0] req1_rb_i,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_err_o,
    output logic        md_valid_o,
    output logic [7:0]  md_inst_o,
    output logic [31:0] md_ra_o,
    output logic [31:0] md_rb_o,
    input  logic        md_ready_i,
    input  logic [31:0] md_result_i,
    output logic        busy_o
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              port_q, port_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       ra_q, ra_d;
    logic [31:0]       rb_q, rb_d;
    logic [31:0]       result_q, result_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              grant_valid;
    logic              grant_port;
    logic              rsp_ack;

    // rr_q names the port that wins a tie, i.e. the one not granted last.
    always_comb begin
        grant_valid = req0_valid_i | req1_valid_i;
        grant_port  = (req0_valid_i & req1_valid_i) ? rr_q : req1_valid_i;
        rsp_ack     = port_q ? rsp1_ready_i : rsp0_ready_i;
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        port_d       = port_q;
        op_d         = op_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        result_d     = result_q;
        err_d        = err_q;
        wd_d         = wd_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        rsp_result_o = 32'd0;
        rsp_err_o    = 1'b0;
        md_valid_o   = 1'b0;
        md_inst_o    = 8'd0;
        md_ra_o      = 32'd0;
        md_rb_o      = 32'd0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    req0_ready_o = ~grant_port;
                    req1_ready_o = grant_port;
                    port_d       = grant_port;
                    op_d         = grant_port ? req1_op_i : req0_op_i;
                    ra_d         = grant_port ? req1_ra_i : req0_ra_i;
                    rb_d         = grant_port ? req1_rb_i : req0_rb_i;
                    rr_d         = ~grant_port;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                md_valid_o = 1'b1;
                md_inst_o  = 8'b1 << op_q;
                md_ra_o    = ra_q;
                md_rb_o    = rb_q;
                wd_d       = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
                if (md_ready_i) begin
                    result_d = md_result_i;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    result_d = 32'd0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                rsp0_valid_o = ~port_q;
                rsp1_valid_o = port_q;
                rsp_result_o = result_q;
                rsp_err_o    = err_q;
                if (rsp_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= 1'b0;
            port_q   <= 1'b0;
            op_q     <= 3'd0;
            ra_q     <= 32'd0;
            rb_q     <= 32'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            port_q   <= port_d;
            op_q     <= op_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            result_q <= result_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end
endmodule
